timer_device: RTL and testbench

- Memory-mapped countdown timer. It is the interrupt source on the CPU's external-interrupt lines: its IRQ output drives one bit of the HWInt vector consumed by the coprocessor-0 exception unit.
- The CPU programs it through the bridge with plain sw/lw: CTRL, PRESET and COUNT registers.
- On expiry it raises IRQ: level-held in one-shot mode, single-cycle pulse in auto-reload mode.

---
 rtl/timer_device_pkg.sv | 21 ++
 rtl/timer_device_if.sv | 12 +
 rtl/timer_device.sv | 99 +++++++++
 tb/tb_timer_device.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_device_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// mode encodings, FSM state type and default base address.
package timer_device_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    localparam logic [31:0] TC_DEFAULT_BASE = 32'h0000_7F00;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/timer_device_if.sv
// CPU-side bus into the timer's 16-byte register window.
// Bus: no handshake. A write commits on the rising edge where WE is high and
// Addr selects the window; Dout is combinational read data for Addr.
interface timer_device_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_device.sv
// Countdown timer with CTRL/PRESET/COUNT registers; raises IRQ on expiry,
// level-held in one-shot mode and a single-cycle pulse in auto-reload mode.
module timer_device
    import timer_device_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = TC_DEFAULT_BASE,
    parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    timer_device_if.slave bus,
    output logic          IRQ,
    output logic [1:0]    dbg_state
);

    tc_state_e   state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        sel;
    logic [1:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        reload;
    logic        unused_bits;

    assign sel       = (bus.Addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = bus.Addr[3:2];
    assign wr_ctrl   = sel && bus.WE && (reg_idx == TC_CTRL);
    assign wr_preset = sel && bus.WE && (reg_idx == TC_PRESET);
    assign reload    = (ctrl[2:1] == TC_MODE_RELOAD);

    assign unused_bits = ^{bus.Addr[1:0], bus.Din[31:4]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TC_IDLE;
            ctrl     <= 4'd0;
            preset   <= RST_PRESET;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                TC_IDLE: begin
                    if (ctrl[0]) state <= TC_LOAD;
                end
                TC_LOAD: begin
                    count <= preset;
                    state <= TC_CNT;
                end
                TC_CNT: begin
                    if (!ctrl[0]) begin
                        state <= TC_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Expiry at <=1 so PRESET=0 behaves like 1 and COUNT never wraps.
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= TC_INT;
                    end
                end
                TC_INT: begin
                    if (reload) begin
                        irq_flag <= 1'b0;
                        state    <= TC_LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= TC_IDLE;
                    end
                end
                default: state <= TC_IDLE;
            endcase

            // Bus writes come last so they override the FSM on the same edge.
            if (wr_ctrl) ctrl <= bus.Din[3:0];
            if (wr_preset) preset <= bus.Din;
            if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        if (sel) begin
            case (reg_idx)
                TC_CTRL:   bus.Dout = {28'd0, ctrl};
                TC_PRESET: bus.Dout = preset;
                TC_COUNT:  bus.Dout = count;
                default:   bus.Dout = 32'd0;
            endcase
        end
    end

    assign IRQ       = irq_flag & ctrl[3];
    assign dbg_state = state;

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: directed scenario tasks plus a randomized run
// checked every cycle against a behavioural register-level model.
module tb_timer_device;

    localparam logic [31:0] BASE  = 32'h0000_7F00;
    localparam logic [31:0] OTHER = 32'h0000_7F10;
    localparam logic [31:0] RSTP  = 32'h0000_0004;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       irq;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_mis = 0;

    timer_device_if bus_if();

    timer_device #(.BASE_ADDR(BASE), .RST_PRESET(RSTP)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .IRQ       (irq),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: registers plus a phase number (0 idle, 1 load, 2 run, 3 expired).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    logic [1:0]  m_phase;
    logic        m_wr_ctrl;
    logic        m_wr_preset;

    assign m_wr_ctrl   = bus_if.WE && (bus_if.Addr[31:4] == BASE[31:4]) && (bus_if.Addr[3:2] == 2'd0);
    assign m_wr_preset = bus_if.WE && (bus_if.Addr[31:4] == BASE[31:4]) && (bus_if.Addr[3:2] == 2'd1);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl   <= 4'd0;
            m_preset <= RSTP;
            m_count  <= 32'd0;
            m_flag   <= 1'b0;
            m_phase  <= 2'd0;
        end else begin
            if (m_phase == 2'd0) begin
                if (m_ctrl[0]) m_phase <= 2'd1;
            end else if (m_phase == 2'd1) begin
                m_count <= m_preset;
                m_phase <= 2'd2;
            end else if (m_phase == 2'd2) begin
                if (!m_ctrl[0]) m_phase <= 2'd0;
                else if (m_count <= 32'd1) begin
                    m_count <= 32'd0;
                    m_flag  <= 1'b1;
                    m_phase <= 2'd3;
                end else m_count <= m_count - 32'd1;
            end else begin
                if (m_ctrl[2:1] == 2'b01) begin
                    m_flag  <= 1'b0;
                    m_phase <= 2'd1;
                end else begin
                    m_ctrl[0] <= 1'b0;
                    m_phase   <= 2'd0;
                end
            end
            if (m_wr_ctrl) m_ctrl <= bus_if.Din[3:0];
            if (m_wr_preset) m_preset <= bus_if.Din;
            if (m_wr_ctrl || m_wr_preset) m_flag <= 1'b0;
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus_if.WE   = 1'b0;
        bus_if.Addr = BASE;
        bus_if.Din  = 32'd0;
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        bus_if.Addr = BASE | {28'd0, r, 2'b00};
        bus_if.WE   = 1'b1;
        bus_if.Din  = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [31:0] d);
        bus_if.WE   = 1'b0;
        bus_if.Addr = BASE | {28'd0, r, 2'b00};
        #1;
        d = bus_if.Dout;
    endtask

    task automatic do_reset();
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [31:0] d;
        bus_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_mis++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        read_reg(2'd0, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL reset_ctrl got %h want 0", d); end
        read_reg(2'd1, d);
        n_cmp++; if (d !== RSTP) begin n_mis++; $display("FAIL reset_preset got %h want %h", d, RSTP); end
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL reset_count got %h want 0", d); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic        e;
        do_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            e = (k >= 7);
            n_cmp++; if (irq !== e) begin n_mis++; $display("FAIL oneshot_irq edge %0d got %b want %b", k, irq, e); end
        end
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL oneshot_count got %h want 0", d); end
        read_reg(2'd0, d);
        n_cmp++; if (d !== 32'h8) begin n_mis++; $display("FAIL oneshot_ctrl got %h want 8", d); end
        repeat (5) @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_hold got %b want 1", irq); end
        bus_write(2'd0, 32'h8);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL oneshot_clear got %b want 0", irq); end
    endtask

    task automatic test_reload();
        logic [31:0] d;
        logic [31:0] seq [5];
        logic [31:0] ec;
        logic        e;
        seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            e  = (k >= 5) && (((k - 5) % 5) == 0);
            ec = (k < 2) ? 32'd0 : seq[(k - 2) % 5];
            n_cmp++; if (irq !== e) begin n_mis++; $display("FAIL reload_irq edge %0d got %b want %b", k, irq, e); end
            read_reg(2'd2, d);
            n_cmp++; if (d !== ec) begin n_mis++; $display("FAIL reload_count edge %0d got %0d want %0d", k, d, ec); end
        end
        read_reg(2'd0, d);
        n_cmp++; if (d !== 32'hB) begin n_mis++; $display("FAIL reload_ctrl got %h want b", d); end
    endtask

    task automatic test_mask();
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL mask_irq edge %0d got %b want 0", k, irq); end
            if (k == 4) begin
                n_cmp++; if (dbg_state !== 2'd3) begin n_mis++; $display("FAIL mask_expired state got %0d want 3", dbg_state); end
            end
        end
        bus_write(2'd0, 32'h8);
        repeat (3) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL mask_unmask got %b want 0", irq); end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        logic        found;
        logic        seen;
        do_reset();
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            read_reg(2'd2, d);
            if (d == 32'd40) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_mis++; $display("FAIL disable_reach40 got %0d want 40 (timeout)", d); end
        bus_write(2'd0, 32'h8);
        repeat (2) @(negedge clk);
        n_cmp++; if (dbg_state !== 2'd0) begin n_mis++; $display("FAIL disable_state got %0d want 0", dbg_state); end
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'd39) begin n_mis++; $display("FAIL disable_count got %0d want 39", d); end
        n_cmp++; if (d !== m_count) begin n_mis++; $display("FAIL disable_model got %0d want %0d", d, m_count); end
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (irq !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_mis++; $display("FAIL disable_noirq got 1 want 0"); end
    endtask

    task automatic test_preset_edges();
        logic [31:0] d;
        logic        e;
        for (int p = 0; p <= 1; p++) begin
            do_reset();
            bus_write(2'd1, 32'(p));
            bus_write(2'd0, 32'h9);
            for (int k = 0; k <= 5; k++) begin
                @(negedge clk);
                e = (k >= 3);
                n_cmp++; if (irq !== e) begin n_mis++; $display("FAIL preset%0d_irq edge %0d got %b want %b", p, k, irq, e); end
            end
        end
        do_reset();
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k < 10; k++) @(negedge clk);
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'hFFFF_FFF8) begin n_mis++; $display("FAIL big_count_run got %h want fffffff8", d); end
        bus_write(2'd0, 32'h8);
        repeat (3) @(negedge clk);
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'hFFFF_FFF7) begin n_mis++; $display("FAIL big_count_frozen got %h want fffffff7", d); end
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL big_irq got %b want 0", irq); end
        bus_write(2'd2, 32'h55);
        @(negedge clk);
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'hFFFF_FFF7) begin n_mis++; $display("FAIL count_ro got %h want fffffff7", d); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        read_reg(2'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL reserved_read got %h want 0", d); end
        bus_if.Addr = OTHER; bus_if.WE = 1'b1; bus_if.Din = 32'h9;
        @(posedge clk); #1; bus_idle();
        @(negedge clk);
        bus_if.Addr = OTHER; #1;
        n_cmp++; if (bus_if.Dout !== 32'd0) begin n_mis++; $display("FAIL unselected_read got %h want 0", bus_if.Dout); end
        read_reg(2'd0, d);
        n_cmp++; if (d !== 32'h8) begin n_mis++; $display("FAIL unselected_write got %h want 8", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (6) @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_mis++; $display("FAIL areset_pre_irq got %b want 1", irq); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL areset_irq got %b want 0", irq); end
        read_reg(2'd0, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL areset_ctrl got %h want 0", d); end
        read_reg(2'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_mis++; $display("FAIL areset_count got %h want 0", d); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_reg(2'd1, d);
        n_cmp++; if (d !== RSTP) begin n_mis++; $display("FAIL areset_preset got %h want %h", d, RSTP); end
        n_cmp++; if (irq !== 1'b0) begin n_mis++; $display("FAIL areset_after got %b want 0", irq); end
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] d;
        logic [31:0] er;
        logic        ei;
        do_reset();
        repeat (600) begin
            @(posedge clk);
            #1;
            op = $urandom_range(0, 99);
            d  = $urandom();
            bus_if.WE = 1'b0;
            if (op < 12) begin
                d[0] = ($urandom_range(0, 9) < 8);
                bus_if.Addr = BASE | 32'($urandom_range(0, 3));
                bus_if.WE = 1'b1;
            end else if (op < 18) begin
                if ($urandom_range(0, 9) != 0) d = 32'($urandom_range(0, 6));
                bus_if.Addr = BASE | 32'h4 | 32'($urandom_range(0, 3));
                bus_if.WE = 1'b1;
            end else if (op < 21) begin
                bus_if.Addr = BASE | 32'h8;
                bus_if.WE = 1'b1;
            end else if (op < 23) begin
                bus_if.Addr = BASE | 32'hC;
                bus_if.WE = 1'b1;
            end else if (op < 26) begin
                bus_if.Addr = OTHER | 32'($urandom_range(0, 15));
                bus_if.WE = 1'b1;
            end else begin
                bus_if.Addr = (($urandom_range(0, 99) < 85) ? BASE : OTHER) | 32'($urandom_range(0, 15));
            end
            bus_if.Din = d;
            @(negedge clk);
            ei = m_flag & m_ctrl[3];
            er = m_read(bus_if.Addr);
            n_cmp++; if (irq !== ei) begin n_mis++; $display("FAIL rand_irq t=%0t got %b want %b", $time, irq, ei); end
            n_cmp++; if (dbg_state !== m_phase) begin n_mis++; $display("FAIL rand_state t=%0t got %0d want %0d", $time, dbg_state, m_phase); end
            n_cmp++; if (bus_if.Dout !== er) begin n_mis++; $display("FAIL rand_dout t=%0t addr %h got %h want %h", $time, bus_if.Addr, bus_if.Dout, er); end
        end
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus_idle();
        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_disable();
        test_preset_edges();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
